// File: rtl/uart_word_packer_pkg.sv
// -----------------------------------------------------------------------------
// uart_word_packer_pkg
//   Shared definitions for the UART receive word packer and its strobe
//   detector: FSM state encoding, logic level constants, default sizes and
//   the byte-slot mapping helper.
// -----------------------------------------------------------------------------
package uart_word_packer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PUSH = 2'd2
    } state_t;

    localparam logic HI = 1'b1;
    localparam logic LO = 1'b0;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_BYTES       = 8;
    localparam int DEF_TIMEOUT_CYC = 100000;

    // Word slot that receives byte number k of a word.
    // LSB-first fills slot 0 upward; MSB-first fills slot bytes-1 downward.
    function automatic int unsigned slot_of(input int unsigned k,
                                            input int unsigned bytes,
                                            input logic        msb);
        return msb ? (bytes - 1 - k) : k;
    endfunction

endpackage

// File: rtl/uart_word_packer_rx_strobe_det.sv
// -----------------------------------------------------------------------------
// rx_strobe_det
//   Rising-edge detector on the receiver byte-ready level. Produces a
//   one-cycle strobe for each low-to-high transition, so a level held high
//   yields exactly one strobe. Shared with the TX path.
//
//   Ports
//     clk_i    in   1   clock, rising edge
//     rst_i    in   1   asynchronous reset, active-high
//     level_i  in   1   ready level, synchronous to clk_i
//     strb_o   out  1   level_i & ~(level_i delayed one cycle)
// -----------------------------------------------------------------------------
module rx_strobe_det
    import uart_word_packer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic strb_o
);

    logic ready_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= LO;
        end else begin
            ready_q <= level_i;
        end
    end

    assign strb_o = level_i & ~ready_q;

endmodule

// File: rtl/uart_word_packer.sv
// -----------------------------------------------------------------------------
// uart_word_packer
//   Packs BYTES consecutive UART receiver bytes into one FIFO word and issues
//   a single-cycle push per word. Supports LSB-first or MSB-first byte order
//   (latched with the first byte of each word), waits indefinitely on
//   fifo_full, flags bytes dropped during that wait (overrun) and, when
//   built with WORD_TIMEOUT_EN defined, discards a partial word after
//   TIMEOUT_CYC idle cycles (timeout_err). Without WORD_TIMEOUT_EN the
//   partial word waits forever and timeout_err_o is tied low.
//
//   Parameters
//     DATA_W       bits per byte
//     BYTES        bytes per word (>= 1)
//     TIMEOUT_CYC  allowed idle cycles between bytes of a word (>= 2)
//
//   Ports
//     sys_clk_i      in   1               clock, rising edge
//     sys_rst_l_i    in   1               asynchronous reset, active-high
//     rec_ready_i    in   1               receiver byte-ready level
//     rec_data_i     in   DATA_W          received byte
//     msb_first_i    in   1               byte order select
//     fifo_full_i    in   1               FIFO back-pressure
//     clr_err_i      in   1               clear sticky flags
//     push_o         out  1               one-cycle FIFO write strobe
//     fifo_data_o    out  BYTES*DATA_W    assembled word
//     byte_cnt_o     out  clog2(BYTES+1)  bytes held in current word
//     busy_o         out  1               FSM not idle
//     overrun_o      out  1               sticky byte-dropped flag
//     timeout_err_o  out  1               sticky partial-word-discarded flag
//
//   FSM
//     state | meaning
//     IDLE  | no bytes held, waiting for byte 0
//     LOAD  | partial word, collecting bytes 1..BYTES-1
//     PUSH  | full word held, pushing when the FIFO has room
// -----------------------------------------------------------------------------
module uart_word_packer
    import uart_word_packer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BYTES       = DEF_BYTES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int WORD_W     = BYTES * DATA_W,
    localparam int CNT_W      = $clog2(BYTES + 1)
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_l_i,
    input  logic              rec_ready_i,
    input  logic [DATA_W-1:0] rec_data_i,
    input  logic              msb_first_i,
    input  logic              fifo_full_i,
    input  logic              clr_err_i,
    output logic              push_o,
    output logic [WORD_W-1:0] fifo_data_o,
    output logic [CNT_W-1:0]  byte_cnt_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              timeout_err_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

    if (BYTES < 1 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_word_packer: BYTES must be >= 1 and TIMEOUT_CYC >= 2");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                msb_lat_q, msb_lat_d;
    logic                overrun_q, overrun_d;

    logic                strb;
    logic                push;
    logic                tmo_hit;

    logic                wr_en;
    logic [CNT_W-1:0]    wr_k;
    logic                wr_msb;
    int unsigned         wr_slot;

    rx_strobe_det u_strobe (
        .clk_i   (sys_clk_i),
        .rst_i   (sys_rst_l_i),
        .level_i (rec_ready_i),
        .strb_o  (strb)
    );

    assign push = (state_q == PUSH) & ~fifo_full_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        msb_lat_d = msb_lat_q;
        overrun_d = overrun_q & ~clr_err_i;
        wr_en     = LO;
        wr_k      = '0;
        wr_msb    = msb_lat_q;

        case (state_q)
            IDLE: begin
                if (strb) begin
                    wr_en     = HI;
                    wr_msb    = msb_first_i;
                    msb_lat_d = msb_first_i;
                    cnt_d     = CNT_W'(1);
                    state_d   = (BYTES == 1) ? PUSH : LOAD;
                end
            end
            LOAD: begin
                if (strb) begin
                    wr_en = HI;
                    wr_k  = cnt_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = PUSH;
                    end
                end else if (tmo_hit) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            PUSH: begin
                if (fifo_full_i) begin
                    // Word must stay intact while waiting; the byte is lost.
                    if (strb) begin
                        overrun_d = HI;
                    end
                end else if (strb) begin
                    // Pushing now, so the new byte starts the next word.
                    wr_en     = HI;
                    wr_msb    = msb_first_i;
                    msb_lat_d = msb_first_i;
                    cnt_d     = CNT_W'(1);
                    state_d   = (BYTES == 1) ? PUSH : LOAD;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign wr_slot = slot_of(32'(wr_k), BYTES, wr_msb);

    always_comb begin
        word_d = word_q;
        for (int unsigned s = 0; s < BYTES; s++) begin
            if (wr_en && (wr_slot == s)) begin
                word_d[s*DATA_W +: DATA_W] = rec_data_i;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_l_i) begin
        if (sys_rst_l_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            msb_lat_q <= LO;
            overrun_q <= LO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            msb_lat_q <= msb_lat_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef WORD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             to_err_q, to_err_d;

    assign tmo_hit = (state_q == LOAD) && (tmo_q == TMO_LIM);

    // Counter runs only while a partial word is held; any byte restarts it.
    always_comb begin
        if (strb || (state_q != LOAD) || tmo_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        // A byte arriving in the timeout cycle is kept, so no error then.
        to_err_d = (to_err_q & ~clr_err_i) | (tmo_hit & ~strb);
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_l_i) begin
        if (sys_rst_l_i) begin
            tmo_q    <= '0;
            to_err_q <= LO;
        end else begin
            tmo_q    <= tmo_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err_o = to_err_q;
`else
    assign tmo_hit       = LO;
    assign timeout_err_o = LO;
`endif

    assign push_o      = push;
    assign fifo_data_o = word_q;
    assign byte_cnt_o  = cnt_q;
    assign busy_o      = (state_q != IDLE);
    assign overrun_o   = overrun_q;

endmodule
